// File: rtl/cache_req_arbiter_if.sv
// Request, cache-datapath and RAM signals of the cache front-end arbiter.
// master = arbiter side, slave = requesters/cache/RAM side.
interface cache_req_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [DATA_W-1:0]   resp_data;
  logic                cache_en;
  logic                cache_mode;
  logic [1:0]          cache_index;
  logic [ADDR_W-3:0]   cache_tag;
  logic [DATA_W-1:0]   cache_wdata;
  logic                cache_hit;
  logic [DATA_W-1:0]   cache_rdata;
  logic                cache_victim_dirty;
  logic [ADDR_W-3:0]   cache_victim_tag;
  logic [DATA_W-1:0]   cache_victim_data;
  logic                cache_fill;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data,
    output cache_en, cache_mode, cache_index, cache_tag,
    output cache_wdata, cache_fill,
    input  cache_hit, cache_rdata, cache_victim_dirty,
    input  cache_victim_tag, cache_victim_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data,
    input  cache_en, cache_mode, cache_index, cache_tag,
    input  cache_wdata, cache_fill,
    output cache_hit, cache_rdata, cache_victim_dirty,
    output cache_victim_tag, cache_victim_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Two-requester front end for the 2-way write-back cache:
// lookup, optional victim write-back, optional fill, response.
module cache_req_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RR_EN  = 1
) (
  input logic clock,
  input logic reset,
  cache_req_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, LOOKUP, WBACK, FILL, RESP
  } state_t;

  state_t state_q, state_d;
  logic rr_ptr_q, rr_ptr_d;
  logic id_q, id_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0] req_ready_q, req_ready_d;
  logic [1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic cache_en_q, cache_en_d;
  logic cache_mode_q, cache_mode_d;
  logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;
  logic cache_fill_q, cache_fill_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic win;
  logic enter_fill;

  always_comb begin
    if (RR_EN != 0 && rr_ptr_q)
      win = bus.req_valid[1];
    else
      win = !bus.req_valid[0];
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    req_ready_d   = '0;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;
    cache_en_d    = 1'b0;
    cache_mode_d  = cache_mode_q;
    cache_wdata_d = cache_wdata_q;
    cache_fill_d  = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    enter_fill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_d[win] = 1'b1;
          cache_en_d = 1'b1;
          id_d = win;
          wr_d = bus.req_write[win];
          addr_d = win ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                       : bus.req_addr[ADDR_W-1:0];
          wdata_d = win ? bus.req_wdata[2*DATA_W-1:DATA_W]
                        : bus.req_wdata[DATA_W-1:0];
          cache_mode_d = wr_d;
          cache_wdata_d = wdata_d;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // cache result is valid the cycle after the cache_en strobe
        if (!cache_en_q) begin
          if (bus.cache_hit) begin
            resp_valid_d[id_q] = 1'b1;
            resp_data_d = wr_q ? wdata_q : bus.cache_rdata;
            state_d = RESP;
          end else if (bus.cache_victim_dirty) begin
            mem_req_d = 1'b1;
            mem_we_d = 1'b1;
            mem_addr_d = {bus.cache_victim_tag, addr_q[1:0]};
            mem_wdata_d = bus.cache_victim_data;
            state_d = WBACK;
          end else begin
            enter_fill = 1'b1;
          end
        end
      end
      WBACK: begin
        if (mem_req_q && bus.mem_ack) begin
          mem_req_d = 1'b0;
          enter_fill = 1'b1;
        end
      end
      FILL: begin
        if (wr_q) begin
          resp_valid_d[id_q] = 1'b1;
          resp_data_d = wdata_q;
          state_d = RESP;
        end else if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_we_d = 1'b0;
          mem_addr_d = addr_q;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          cache_fill_d = 1'b1;
          cache_mode_d = 1'b0;
          cache_wdata_d = bus.mem_rdata;
          resp_valid_d[id_q] = 1'b1;
          resp_data_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a write miss installs its own data without reading RAM
    if (enter_fill) begin
      state_d = FILL;
      if (wr_q) begin
        cache_fill_d = 1'b1;
        cache_mode_d = 1'b1;
        cache_wdata_d = wdata_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      id_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      req_ready_q   <= '0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
      cache_en_q    <= 1'b0;
      cache_mode_q  <= 1'b0;
      cache_wdata_q <= '0;
      cache_fill_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      cache_en_q    <= cache_en_d;
      cache_mode_q  <= cache_mode_d;
      cache_wdata_q <= cache_wdata_d;
      cache_fill_q  <= cache_fill_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.cache_en    = cache_en_q;
  assign bus.cache_mode  = cache_mode_q;
  assign bus.cache_index = addr_q[1:0];
  assign bus.cache_tag   = addr_q[ADDR_W-1:2];
  assign bus.cache_wdata = cache_wdata_q;
  assign bus.cache_fill  = cache_fill_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed scoreboard bench for cache_req_arbiter (round-robin instance
// plus a fixed-priority instance for the arbitration check).
module tb_cache_req_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en1 = 1'b0;
  always #5 clock = ~clock;

  cache_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  cache_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  cache_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  cache_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  assign bus1.req_valid = en1 ? bus0.req_valid : 2'b00;
  assign bus1.req_write = bus0.req_write;
  assign bus1.req_addr = bus0.req_addr;
  assign bus1.req_wdata = bus0.req_wdata;
  assign bus1.cache_hit = bus0.cache_hit;
  assign bus1.cache_rdata = bus0.cache_rdata;
  assign bus1.cache_victim_dirty = bus0.cache_victim_dirty;
  assign bus1.cache_victim_tag = bus0.cache_victim_tag;
  assign bus1.cache_victim_data = bus0.cache_victim_data;
  assign bus1.mem_ack = 1'b0;
  assign bus1.mem_rdata = '0;

  // RAM model: acks ram_lat cycles after mem_req rises
  int ram_lat = 3;
  int ram_cnt;
  logic [DW-1:0] ram_rd = '0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus0.mem_ack <= 1'b0;
      bus0.mem_rdata <= '0;
      ram_cnt <= 0;
    end else begin
      bus0.mem_ack <= 1'b0;
      if (bus0.mem_req && !bus0.mem_ack) begin
        if (ram_cnt >= ram_lat - 1) begin
          bus0.mem_ack <= 1'b1;
          bus0.mem_rdata <= ram_rd;
          ram_cnt <= 0;
        end else begin
          ram_cnt <= ram_cnt + 1;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  int rsp_cyc = 0;
  int resp_cnt = 0;
  int mem_acks = 0;
  int mem_req_cycles = 0;
  bit hold = 1'b0;
  int grants[$];
  int grants1[$];
  logic [9:0]  exp_resp[$];
  logic [18:0] exp_mem[$];
  logic [8:0]  exp_fill[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [9:0] er;
    logic [18:0] em;
    logic [8:0] ef;
    @(negedge clock);
    cyc++;
    if (bus0.mem_req === 1'b1) mem_req_cycles++;
    if (bus0.req_ready != 2'b00) begin
      rdy_cyc = cyc;
      grants.push_back(int'(bus0.req_ready[1]));
      if (!hold) bus0.req_valid = bus0.req_valid & ~bus0.req_ready;
    end
    if (bus1.req_ready != 2'b00)
      grants1.push_back(int'(bus1.req_ready[1]));
    if (bus0.resp_valid != 2'b00) begin
      rsp_cyc = cyc;
      resp_cnt++;
      chk("resp_expected", 64'(exp_resp.size() > 0), 1);
      if (exp_resp.size() > 0) begin
        er = exp_resp.pop_front();
        chk("resp", {bus0.resp_valid, bus0.resp_data}, er);
      end
    end
    if (bus0.mem_req === 1'b1 && bus0.mem_ack === 1'b1) begin
      mem_acks++;
      chk("mem_expected", 64'(exp_mem.size() > 0), 1);
      if (exp_mem.size() > 0) begin
        em = exp_mem.pop_front();
        chk("mem_access", {bus0.mem_we, bus0.mem_addr,
            bus0.mem_we ? bus0.mem_wdata : 8'h00}, em);
      end
    end
    if (bus0.cache_fill === 1'b1) begin
      chk("fill_expected", 64'(exp_fill.size() > 0), 1);
      if (exp_fill.size() > 0) begin
        ef = exp_fill.pop_front();
        chk("fill", {bus0.cache_mode, bus0.cache_wdata}, ef);
      end
    end
  endtask

  task automatic wait_resp(int budget);
    int start;
    int n;
    start = resp_cnt;
    n = 0;
    while (resp_cnt == start && n < budget) begin
      step();
      n++;
    end
    chk("resp_timeout", 64'(resp_cnt != start), 1);
  endtask

  task automatic req(int id, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    bus0.req_write[id] = wr;
    bus0.req_addr[id*AW +: AW] = a;
    bus0.req_wdata[id*DW +: DW] = d;
    bus0.req_valid[id] = 1'b1;
  endtask

  task automatic cache(bit hit, logic [DW-1:0] rd, bit dirty,
                       logic [AW-3:0] vtag, logic [DW-1:0] vdata);
    bus0.cache_hit = hit;
    bus0.cache_rdata = rd;
    bus0.cache_victim_dirty = dirty;
    bus0.cache_victim_tag = vtag;
    bus0.cache_victim_data = vdata;
  endtask

  initial begin
    int n;
    int acks0;
    int resp0;
    bus0.req_valid = '0;
    bus0.req_write = '0;
    bus0.req_addr = '0;
    bus0.req_wdata = '0;
    cache(1'b0, 8'h00, 1'b0, '0, 8'h00);

    // reset state
    step();
    step();
    chk("rst_outputs", {bus0.req_ready, bus0.resp_valid, bus0.resp_data,
        bus0.cache_en, bus0.cache_mode, bus0.cache_index, bus0.cache_tag,
        bus0.cache_wdata, bus0.cache_fill, bus0.mem_req, bus0.mem_we,
        bus0.mem_addr, bus0.mem_wdata}, 0);
    chk("rst_busy", bus0.busy, 0);
    reset = 1'b0;

    // both valid: requester 0 first, read hit
    cache(1'b1, 8'h03, 1'b0, '0, 8'h00);
    req(0, 1'b0, 10'h001, 8'h00);
    req(1, 1'b0, 10'h01C, 8'h00);
    exp_resp.push_back({2'b01, 8'h03});
    wait_resp(20);
    chk("first_grant", grants[0], 0);
    chk("hit_latency", rsp_cyc - rdy_cyc, 2);
    chk("hit_no_mem", mem_req_cycles, 0);

    // requester 1 read miss, clean victim
    cache(1'b0, 8'h00, 1'b0, 8'h3F, 8'h99);
    ram_rd = 8'h07;
    ram_lat = 3;
    exp_mem.push_back({1'b0, 10'h01C, 8'h00});
    exp_fill.push_back({1'b0, 8'h07});
    exp_resp.push_back({2'b10, 8'h07});
    wait_resp(40);
    chk("second_grant", grants[$], 1);
    chk("miss_mem_done", exp_mem.size(), 0);
    chk("miss_fill_done", exp_fill.size(), 0);

    // requester 0 write miss, dirty victim
    acks0 = mem_acks;
    cache(1'b0, 8'h00, 1'b1, 8'h05, 8'h05);
    req(0, 1'b1, 10'h026, 8'hAA);
    exp_mem.push_back({1'b1, 10'h016, 8'h05});
    exp_fill.push_back({1'b1, 8'hAA});
    exp_resp.push_back({2'b01, 8'hAA});
    wait_resp(60);
    chk("wmiss_one_ram_access", mem_acks - acks0, 1);
    chk("wmiss_fill_done", exp_fill.size(), 0);

    // requester 1 hit so that rr_ptr points at requester 0
    cache(1'b1, 8'h5A, 1'b0, '0, 8'h00);
    req(1, 1'b0, 10'h010, 8'h00);
    exp_resp.push_back({2'b10, 8'h5A});
    wait_resp(20);

    // both valid continuously, all hits
    grants.delete();
    grants1.delete();
    hold = 1'b1;
    req(0, 1'b0, 10'h004, 8'h00);
    req(1, 1'b0, 10'h008, 8'h00);
    en1 = 1'b1;
    exp_resp.push_back({2'b01, 8'h5A});
    exp_resp.push_back({2'b10, 8'h5A});
    exp_resp.push_back({2'b01, 8'h5A});
    exp_resp.push_back({2'b10, 8'h5A});
    for (int i = 0; i < 4; i++) wait_resp(20);
    bus0.req_valid = 2'b00;
    en1 = 1'b0;
    hold = 1'b0;
    chk("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("rr_grant", grants[i], i % 2);
    chk("fixed_grant_count", grants1.size(), 4);
    for (int i = 0; i < grants1.size(); i++)
      chk("fixed_grant", grants1[i], 0);
    step();
    step();

    // reset while write-back is outstanding
    ram_lat = 50;
    cache(1'b0, 8'h00, 1'b1, 8'h11, 8'h22);
    req(0, 1'b0, 10'h0F3, 8'h00);
    n = 0;
    while (bus0.mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wb_request", {bus0.mem_req, bus0.mem_we, bus0.mem_addr,
        bus0.mem_wdata}, {1'b1, 1'b1, 10'h047, 8'h22});
    resp0 = resp_cnt;
    reset = 1'b1;
    #1;
    chk("rst_mem_req_drop", bus0.mem_req, 0);
    chk("rst_busy_drop", bus0.busy, 0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("rst_no_resp", resp_cnt - resp0, 0);

    // next request completes normally
    ram_lat = 3;
    cache(1'b1, 8'h66, 1'b0, '0, 8'h00);
    req(1, 1'b0, 10'h0F3, 8'h00);
    exp_resp.push_back({2'b10, 8'h66});
    wait_resp(20);
    chk("post_rst_grant", grants[$], 1);
    step();
    step();
    chk("queues_drained",
        exp_resp.size() + exp_mem.size() + exp_fill.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
